// File: rtl/ucie_ctl_adapter_rdi_ctl.sv
// Adapter-side RDI link controller: sequences lp_state_req/lp_linkerror against the
// PHY state status and drains a 2-entry main-band transmit buffer toward the PHY.
//
// state          | meaning
// ---------------+-------------------------------------------------------------
// ST_RESET_WAIT  | idle, req=NOP, waiting for start-link with inband presence
// ST_REQ_ACTIVE  | req=Active, timer running until PHY reports Active
// ST_ACTIVE      | link up, req=NOP, transmit buffer drains to PHY
// ST_RETRAIN     | PHY retraining, req=Active, timer running
// ST_LR_REQ      | req=LinkReset, waiting for PHY to report LinkReset
// ST_LR_WAIT     | req=LinkReset, waiting for PHY to fall back to Reset
// ST_LINKERROR   | lp_linkerror latched until cleared, exit once PHY is in Reset
module ucie_ctl_adapter_rdi_ctl #(
    parameter int NBYTES         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start_link,
    input  logic                  i_linkreset_req,
    input  logic                  i_lnkerr_req,
    input  logic                  i_err_clr,
    input  logic                  i_tx_valid,
    input  logic [NBYTES*8-1:0]   i_tx_data,
    output logic                  o_tx_ready,
    input  logic [3:0]            i_pl_state_sts,
    input  logic                  i_pl_inband_pres,
    input  logic                  i_pl_trdy,
    output logic [3:0]            o_lp_state_req,
    output logic                  o_lp_linkerror,
    output logic                  o_lp_irdy,
    output logic                  o_lp_valid,
    output logic [NBYTES*8-1:0]   o_lp_data,
    output logic                  o_link_up,
    output logic                  o_timeout
);

    localparam int DW = NBYTES * 8;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] REQ_NOP       = 4'b0000;
    localparam logic [3:0] REQ_ACTIVE    = 4'b0001;
    localparam logic [3:0] REQ_LINKRESET = 4'b1001;

    localparam logic [3:0] STS_RESET     = 4'b0000;
    localparam logic [3:0] STS_ACTIVE    = 4'b0001;
    localparam logic [3:0] STS_LINKRESET = 4'b1001;
    localparam logic [3:0] STS_LINKERROR = 4'b1010;
    localparam logic [3:0] STS_RETRAIN   = 4'b1011;

    typedef enum logic [2:0] {
        ST_RESET_WAIT,
        ST_REQ_ACTIVE,
        ST_ACTIVE,
        ST_RETRAIN,
        ST_LR_REQ,
        ST_LR_WAIT,
        ST_LINKERROR
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            timer_run;
    logic            timer_done;
    logic            fatal;
    logic            timeout_fire;
    logic            lnkerr_d;
    logic [3:0]      req_d;

    logic [DW-1:0]   mem_q [2];
    logic [DW-1:0]   mem_d [2];
    logic            wr_q, wr_d;
    logic            rd_q, rd_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            push;
    logic            pop;
    logic            flush;
    logic [DW-1:0]   data_d;

    // Link sequencing
    always_comb begin
        state_d      = state_q;
        lnkerr_d     = o_lp_linkerror;
        timeout_fire = 1'b0;
        timer_run    = (state_q == ST_REQ_ACTIVE) || (state_q == ST_RETRAIN);
        timer_done   = timer_run && (timer_q == TMR_LAST);
        fatal        = i_lnkerr_req || (i_pl_state_sts == STS_LINKERROR);

        if (state_q == ST_LINKERROR) begin
            if (i_lnkerr_req) begin
                lnkerr_d = 1'b1;
            end else if (i_err_clr && (i_pl_state_sts == STS_LINKERROR)) begin
                lnkerr_d = 1'b0;
            end
            if (!o_lp_linkerror && (i_pl_state_sts == STS_RESET)) begin
                state_d = ST_RESET_WAIT;
            end
        end else if (fatal) begin
            state_d  = ST_LINKERROR;
            lnkerr_d = 1'b1;
        end else if (timer_done) begin
            state_d      = ST_LINKERROR;
            lnkerr_d     = 1'b1;
            timeout_fire = 1'b1;
        end else if (i_linkreset_req && ((state_q == ST_REQ_ACTIVE) ||
                                         (state_q == ST_ACTIVE) ||
                                         (state_q == ST_RETRAIN))) begin
            state_d = ST_LR_REQ;
        end else if ((state_q == ST_ACTIVE) && (i_pl_state_sts == STS_RETRAIN)) begin
            state_d = ST_RETRAIN;
        end else begin
            case (state_q)
                ST_RESET_WAIT: if (i_start_link && i_pl_inband_pres) state_d = ST_REQ_ACTIVE;
                ST_REQ_ACTIVE: if (i_pl_state_sts == STS_ACTIVE)     state_d = ST_ACTIVE;
                ST_ACTIVE:     if (i_pl_state_sts == STS_RESET)      state_d = ST_RESET_WAIT;
                ST_RETRAIN:    if (i_pl_state_sts == STS_ACTIVE)     state_d = ST_ACTIVE;
                ST_LR_REQ:     if (i_pl_state_sts == STS_LINKRESET)  state_d = ST_LR_WAIT;
                ST_LR_WAIT:    if (i_pl_state_sts == STS_RESET)      state_d = ST_RESET_WAIT;
                default:       state_d = ST_RESET_WAIT;
            endcase
        end

        // Timer restarts from zero on every entry into a timed state.
        if (timer_run && (state_d == state_q)) begin
            timer_d = timer_q + TW'(1);
        end else begin
            timer_d = '0;
        end

        case (state_d)
            ST_REQ_ACTIVE, ST_RETRAIN: req_d = REQ_ACTIVE;
            ST_LR_REQ, ST_LR_WAIT:     req_d = REQ_LINKRESET;
            default:                   req_d = REQ_NOP;
        endcase
    end

    // Transmit buffer; outputs are computed from the post-edge occupancy
    always_comb begin
        push  = i_tx_valid && o_tx_ready;
        pop   = o_lp_valid && i_pl_trdy;
        flush = (state_d == ST_RESET_WAIT) || (state_d == ST_LINKERROR);
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_q] = i_tx_data;
        end
        if (flush) begin
            wr_d  = 1'b0;
            rd_d  = 1'b0;
            cnt_d = 2'd0;
        end else begin
            wr_d  = wr_q ^ push;
            rd_d  = rd_q ^ pop;
            cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        end
        data_d = (cnt_d != 2'd0) ? mem_d[rd_d] : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= ST_RESET_WAIT;
            timer_q        <= '0;
            wr_q           <= 1'b0;
            rd_q           <= 1'b0;
            cnt_q          <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            o_lp_state_req <= REQ_NOP;
            o_lp_linkerror <= 1'b0;
            o_link_up      <= 1'b0;
            o_timeout      <= 1'b0;
            o_tx_ready     <= 1'b0;
            o_lp_valid     <= 1'b0;
            o_lp_irdy      <= 1'b0;
            o_lp_data      <= '0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            wr_q           <= wr_d;
            rd_q           <= rd_d;
            cnt_q          <= cnt_d;
            mem_q          <= mem_d;
            o_lp_state_req <= req_d;
            o_lp_linkerror <= lnkerr_d;
            o_link_up      <= (state_d == ST_ACTIVE);
            o_timeout      <= timeout_fire;
            o_tx_ready     <= (cnt_d != 2'd2) && (state_d == ST_ACTIVE);
            o_lp_valid     <= (cnt_d != 2'd0) && (state_d == ST_ACTIVE);
            o_lp_irdy      <= (cnt_d != 2'd0) && (state_d == ST_ACTIVE);
            o_lp_data      <= data_d;
        end
    end

endmodule
